// File: rtl/des_ctrl_pkg.sv
// Shared constants and state type for the DES round sequencer.
// The PASS state exists only when DES_CTRL_TDES_EN is defined.
package des_ctrl_pkg;

    localparam int DES_ROUNDS  = 16;
    localparam int TDES_PASSES = 3;

    // Bit r is set when round r rotates C/D by two (schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1)
    localparam logic [15:0] DES_SHIFT_SCHED = 16'h7EFC;

`ifdef DES_CTRL_TDES_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        PASS  = 2'd2,
        DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd3
    } state_t;
`endif

    function automatic logic shift_is2(input logic [3:0] r);
        return DES_SHIFT_SCHED[r];
    endfunction

endpackage

// File: rtl/des_shift_sched.sv
// Combinational C/D rotation control for one DES round, encrypt or decrypt.
// Decrypt walks the schedule backwards and skips the rotation in round 0.
module des_shift_sched
    import des_ctrl_pkg::*;
(
    input  logic [3:0] round,
    input  logic       decrypt,
    output logic       shift_en,
    output logic       shift2,
    output logic       shift_right
);

    logic [3:0] sched_idx;

    // 16 - round, modulo 16; round 0 never uses it because the shift is suppressed
    assign sched_idx   = decrypt ? (4'd0 - round) : round;
    assign shift_en    = ~decrypt | (round != 4'd0);
    assign shift2      = shift_en & shift_is2(sched_idx);
    assign shift_right = decrypt;

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES round sequencer: load, 16 round strobes, hold result until taken.
// Define DES_CTRL_TDES_EN to add the triple-DES pass sequencing (PASS state, key_sel).
//
// state | meaning
// IDLE  | waiting for a block, in_ready=1
// ROUND | one round per cycle, round index 0..15
// PASS  | TDES only: reload L/R (swapped) and C/D from the next key
// DONE  | out_valid=1, datapath holds until out_ready
module des_round_ctrl
    import des_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_decrypt,
    input  logic       in_tdes,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       dp_load,
    output logic       dp_pass_load,
    output logic       dp_round_en,
    output logic [3:0] dp_round,
    output logic       dp_shift_en,
    output logic       dp_shift2,
    output logic       dp_shift_right,
    output logic [1:0] dp_key_sel,
    output logic       busy
);

    state_t     state;
    logic [3:0] round;
    logic       decrypt_q;
    logic [1:0] key_sel;
    logic       accept;
    logic       last_round;
    logic       in_round;
    logic       sh_en;
    logic       sh2;
    logic       sh_right;

    assign in_ready   = ~rst & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept     = in_ready & in_valid;
    assign last_round = (round == 4'(DES_ROUNDS - 1));

`ifdef DES_CTRL_TDES_EN
    logic       tdes_q;
    logic       start_dec_q;
    logic [1:0] pass;
    logic       tdes_more;

    assign tdes_more = tdes_q & (pass != 2'(TDES_PASSES - 1));
`else
    logic unused_tdes;

    assign unused_tdes = in_tdes;
    assign key_sel     = 2'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            round     <= 4'd0;
            decrypt_q <= 1'b0;
`ifdef DES_CTRL_TDES_EN
            tdes_q      <= 1'b0;
            start_dec_q <= 1'b0;
            pass        <= 2'd0;
            key_sel     <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state     <= ROUND;
                        round     <= 4'd0;
                        decrypt_q <= in_decrypt;
`ifdef DES_CTRL_TDES_EN
                        tdes_q      <= in_tdes;
                        start_dec_q <= in_decrypt;
                        pass        <= 2'd0;
                        // decrypt chain starts from the last key
                        key_sel     <= (in_tdes & in_decrypt) ? 2'd2 : 2'd0;
`endif
                    end else if ((state == DONE) && out_ready) begin
                        state <= IDLE;
                    end
                end
                ROUND: begin
                    if (last_round) begin
`ifdef DES_CTRL_TDES_EN
                        if (tdes_more) begin
                            // key_sel moves ahead so PASS already presents the next key
                            state     <= PASS;
                            pass      <= pass + 2'd1;
                            key_sel   <= start_dec_q ? (key_sel - 2'd1) : (key_sel + 2'd1);
                            decrypt_q <= ~decrypt_q;
                        end else begin
                            state <= DONE;
                        end
`else
                        state <= DONE;
`endif
                    end else begin
                        round <= round + 4'd1;
                    end
                end
`ifdef DES_CTRL_TDES_EN
                PASS: begin
                    state <= ROUND;
                    round <= 4'd0;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    des_shift_sched u_shift_sched (
        .round       (round),
        .decrypt     (decrypt_q),
        .shift_en    (sh_en),
        .shift2      (sh2),
        .shift_right (sh_right)
    );

    assign in_round       = ~rst & (state == ROUND);
    assign dp_load        = accept;
    assign dp_round_en    = in_round;
    assign dp_round       = in_round ? round : 4'd0;
    assign dp_shift_en    = in_round & sh_en;
    assign dp_shift2      = in_round & sh2;
    assign dp_shift_right = in_round & sh_right;
    assign out_valid      = ~rst & (state == DONE);
    assign busy           = ~rst & (state != IDLE);
    assign dp_key_sel     = rst ? 2'd0 : key_sel;

`ifdef DES_CTRL_TDES_EN
    assign dp_pass_load = ~rst & (state == PASS);
`else
    assign dp_pass_load = 1'b0;
`endif

endmodule
